seg_execute_alu: RTL and testbench
==================================

# seg_execute_alu

Execute-stage ALU with registered EX/MEM output, directly downstream of the ALU control decoder. Consumes the 4-bit ALU control code plus the two ID/EX operands, computes the result in one cycle and latches result, zero flag and destination metadata into the EX/MEM boundary. Supports pipeline stall (hold) and flush (bubble insertion) so the hazard unit can freeze or squash the stage.

## Interface
Parameters:
- NB_DATA, 32, operand/result width
- NB_ALUCTL, 4, ALU control code width
- NB_ADDR, 5, destination register address width

Ports:
- i_clk  in  1  stage clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  ID/EX holds a real instruction
- i_stall  in  1  hold all output registers
- i_flush  in  1  replace captured instruction with a bubble
- i_ALUctl  in  NB_ALUCTL  operation code from ALU control
- i_data_a  in  NB_DATA  operand A (rs)
- i_data_b  in  NB_DATA  operand B (rt or immediate)
- i_rd_addr  in  NB_ADDR  destination register
- i_reg_write  in  1  instruction writes the register file
- o_valid  out  1  EX/MEM holds a real instruction
- o_result  out  NB_DATA  registered ALU result
- o_zero  out  1  registered (result == 0)
- o_rd_addr  out  NB_ADDR  registered destination
- o_reg_write  out  1  registered write enable, forced 0 for bubbles
- o_overflow  out  1  registered signed overflow (only with ALU_OVERFLOW_EN)

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 XOR; any other code gives result 0.
- ADD/SUB wrap modulo 2^NB_DATA; no exception, no trap.
- SLT: signed two's-complement compare a < b; result 1 or 0, zero-extended to NB_DATA.
- o_zero derives from the computed result of the same instruction (SUB of equal operands gives o_zero=1 for BEQ).
- Per-edge priority: reset > flush > stall > load.
  - Flush: o_valid=0, o_reg_write=0, o_result=0, o_zero=0, o_rd_addr=0, o_overflow=0.
  - Stall without flush: every output register keeps its value.
  - Load: all outputs capture new values; o_reg_write = i_reg_write & i_valid; o_valid = i_valid.
- i_valid=0 on a load edge captures a bubble: the ALU result is still latched, but o_valid=0 and o_reg_write=0.

## Timing
- Latency 1 cycle: operands sampled at edge N appear on outputs after edge N.
- Datapath from operands to registers is purely combinational; no multi-cycle ops.
- Reset asserted at any time, including mid-stall, clears immediately: o_valid=0, o_result=0, o_zero=0, o_rd_addr=0, o_reg_write=0, o_overflow=0. The first load is the first edge after deassertion.
- Stall and flush asserted together: flush wins and the bubble is latched.
- Outputs never change while i_stall=1 and i_flush=0, regardless of the inputs.

## Configuration
- ALU_OVERFLOW_EN defined:
  - o_overflow exists.
  - It is set for ADD when the operand signs match and the result sign differs.
  - It is set for SUB when the operand signs differ and the result sign differs from a.
  - It is 0 for all other codes and is cleared by flush and reset.
- ALU_OVERFLOW_EN undefined: port and logic are absent; all other behaviour is identical.

## Structure
- Shared package: ALU code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_XOR) and the NB_ALUCTL width. The ALU control decoder and this block use the same package.
- One sub-module, seg_execute_alu_core: combinational result, zero and overflow from a, b and code. This block adds the stall/flush-controlled EX/MEM register.

## Test plan
- Reset then load ADD with a=0x7FFFFFFF, b=1, rd=3, reg_write=1, valid=1. Next cycle: o_result=0x80000000, o_zero=0, o_rd_addr=3, o_reg_write=1, o_overflow=1 (when enabled).
- SUB with a=b=0x1234: o_result=0, o_zero=1. SLT with a=0xFFFFFFFF, b=1: o_result=1. SLT with a=1, b=0xFFFFFFFF: o_result=0.
- AND/OR/XOR/NOR with a=0xF0F0F0F0, b=0xFF00FF00: results 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F. Code 1111 gives result 0 and o_zero=1.
- Load ADD 5+6, then hold i_stall=1 for 3 cycles while the inputs change: o_result stays 11. Release the stall: the next edge captures the new inputs.
- Assert i_flush and i_stall together while a valid instruction with reg_write=1 is presented: next cycle o_valid=0, o_reg_write=0, o_result=0.
- Assert i_reset asynchronously mid-cycle during a stall with o_result=11: outputs clear before the next edge. The first edge after release loads normally.

Source files
------------

// File: rtl/seg_execute_alu_pkg.sv
// Shared ALU control codes and code width, used by the ALU control decoder
// and by the execute-stage ALU.
package seg_execute_alu_pkg;

   localparam int NB_ALUCTL = 4;

   localparam logic [NB_ALUCTL-1:0] ALU_AND = 4'b0000;
   localparam logic [NB_ALUCTL-1:0] ALU_OR  = 4'b0001;
   localparam logic [NB_ALUCTL-1:0] ALU_ADD = 4'b0010;
   localparam logic [NB_ALUCTL-1:0] ALU_SUB = 4'b0110;
   localparam logic [NB_ALUCTL-1:0] ALU_SLT = 4'b0111;
   localparam logic [NB_ALUCTL-1:0] ALU_NOR = 4'b1100;
   localparam logic [NB_ALUCTL-1:0] ALU_XOR = 4'b1101;

endpackage

// File: rtl/seg_execute_alu_core.sv
// Combinational ALU: result, zero flag and (with ALU_OVERFLOW_EN) signed
// overflow from operands a, b and the ALU control code.
module seg_execute_alu_core
   import seg_execute_alu_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [NB_DATA-1:0]   i_data_a,
   input  logic [NB_DATA-1:0]   i_data_b,
   input  logic [NB_ALUCTL-1:0] i_ALUctl,
   output logic [NB_DATA-1:0]   o_result,
`ifdef ALU_OVERFLOW_EN
   output logic                 o_overflow,
`endif
   output logic                 o_zero
);

   logic [NB_DATA-1:0] sum_s;
   logic [NB_DATA-1:0] diff_s;
   logic               lt_s;
   logic               add_ovf_s;
   logic               sub_ovf_s;
   logic               ovf_s;

   assign sum_s  = i_data_a + i_data_b;
   assign diff_s = i_data_a - i_data_b;
   assign lt_s   = ($signed(i_data_a) < $signed(i_data_b));

   // Overflow: same-sign add flips sign; mixed-sign subtract flips sign of a
   assign add_ovf_s = (i_data_a[NB_DATA-1] == i_data_b[NB_DATA-1]) &&
                      (sum_s[NB_DATA-1]    != i_data_a[NB_DATA-1]);
   assign sub_ovf_s = (i_data_a[NB_DATA-1] != i_data_b[NB_DATA-1]) &&
                      (diff_s[NB_DATA-1]   != i_data_a[NB_DATA-1]);

   always_comb begin
      o_result = {NB_DATA{1'b0}};
      ovf_s    = 1'b0;
      case (i_ALUctl)
         ALU_AND: o_result = i_data_a & i_data_b;
         ALU_OR:  o_result = i_data_a | i_data_b;
         ALU_ADD: begin
            o_result = sum_s;
            ovf_s    = add_ovf_s;
         end
         ALU_SUB: begin
            o_result = diff_s;
            ovf_s    = sub_ovf_s;
         end
         ALU_SLT: o_result = {{(NB_DATA-1){1'b0}}, lt_s};
         ALU_NOR: o_result = ~(i_data_a | i_data_b);
         ALU_XOR: o_result = i_data_a ^ i_data_b;
         default: o_result = {NB_DATA{1'b0}};
      endcase
   end

   assign o_zero = (o_result == {NB_DATA{1'b0}});

`ifdef ALU_OVERFLOW_EN
   assign o_overflow = ovf_s;
`else
   logic unused_ovf_s;
   assign unused_ovf_s = ovf_s;
`endif

endmodule

// File: rtl/seg_execute_alu.sv
// Execute-stage ALU with stall/flush-controlled EX/MEM register.
// Define ALU_OVERFLOW_EN to add the registered o_overflow output.
module seg_execute_alu #(
   parameter int NB_DATA   = 32,
   parameter int NB_ALUCTL = seg_execute_alu_pkg::NB_ALUCTL,
   parameter int NB_ADDR   = 5
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic [NB_ALUCTL-1:0] i_ALUctl,
   input  logic [NB_DATA-1:0]   i_data_a,
   input  logic [NB_DATA-1:0]   i_data_b,
   input  logic [NB_ADDR-1:0]   i_rd_addr,
   input  logic                 i_reg_write,
   output logic                 o_valid,
   output logic [NB_DATA-1:0]   o_result,
   output logic                 o_zero,
   output logic [NB_ADDR-1:0]   o_rd_addr,
`ifdef ALU_OVERFLOW_EN
   output logic                 o_overflow,
`endif
   output logic                 o_reg_write
);

   logic [NB_DATA-1:0] alu_result_s;
   logic               alu_zero_s;
   logic               alu_ovf_s;

   logic               valid_q,     valid_d;
   logic [NB_DATA-1:0] result_q,    result_d;
   logic               zero_q,      zero_d;
   logic [NB_ADDR-1:0] rd_addr_q,   rd_addr_d;
   logic               reg_write_q, reg_write_d;
   logic               overflow_q,  overflow_d;

   seg_execute_alu_core #(
      .NB_DATA (NB_DATA)
   ) u_core (
      .i_data_a   (i_data_a),
      .i_data_b   (i_data_b),
      .i_ALUctl   (i_ALUctl),
      .o_result   (alu_result_s),
`ifdef ALU_OVERFLOW_EN
      .o_overflow (alu_ovf_s),
`endif
      .o_zero     (alu_zero_s)
   );

`ifndef ALU_OVERFLOW_EN
   assign alu_ovf_s = 1'b0;
`endif

   // Next-state: flush beats stall beats load
   always_comb begin
      valid_d     = valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      rd_addr_d   = rd_addr_q;
      reg_write_d = reg_write_q;
      overflow_d  = overflow_q;
      if (i_flush) begin
         valid_d     = 1'b0;
         result_d    = {NB_DATA{1'b0}};
         zero_d      = 1'b0;
         rd_addr_d   = {NB_ADDR{1'b0}};
         reg_write_d = 1'b0;
         overflow_d  = 1'b0;
      end else if (i_stall) begin
         valid_d     = valid_q;
      end else begin
         valid_d     = i_valid;
         result_d    = alu_result_s;
         zero_d      = alu_zero_s;
         rd_addr_d   = i_rd_addr;
         reg_write_d = i_reg_write & i_valid;
         overflow_d  = alu_ovf_s;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q     <= 1'b0;
         result_q    <= {NB_DATA{1'b0}};
         zero_q      <= 1'b0;
         rd_addr_q   <= {NB_ADDR{1'b0}};
         reg_write_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         rd_addr_q   <= rd_addr_d;
         reg_write_q <= reg_write_d;
         overflow_q  <= overflow_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_result    = result_q;
   assign o_zero      = zero_q;
   assign o_rd_addr   = rd_addr_q;
   assign o_reg_write = reg_write_q;
`ifdef ALU_OVERFLOW_EN
   assign o_overflow  = overflow_q;
`else
   logic unused_ovf_q;
   assign unused_ovf_q = overflow_q;
`endif

endmodule

// File: tb/tb_seg_execute_alu.sv
// Directed self-checking bench for seg_execute_alu (overflow checks only
// when ALU_OVERFLOW_EN is defined).
module tb_seg_execute_alu;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        i_stall;
   logic        i_flush;
   logic [3:0]  i_ALUctl;
   logic [31:0] i_data_a;
   logic [31:0] i_data_b;
   logic [4:0]  i_rd_addr;
   logic        i_reg_write;
   logic        o_valid;
   logic [31:0] o_result;
   logic        o_zero;
   logic [4:0]  o_rd_addr;
   logic        o_reg_write;
`ifdef ALU_OVERFLOW_EN
   logic        o_overflow;
`endif

   int checks = 0;
   int errors = 0;

   seg_execute_alu dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_valid     (i_valid),
      .i_stall     (i_stall),
      .i_flush     (i_flush),
      .i_ALUctl    (i_ALUctl),
      .i_data_a    (i_data_a),
      .i_data_b    (i_data_b),
      .i_rd_addr   (i_rd_addr),
      .i_reg_write (i_reg_write),
      .o_valid     (o_valid),
      .o_result    (o_result),
      .o_zero      (o_zero),
      .o_rd_addr   (o_rd_addr),
`ifdef ALU_OVERFLOW_EN
      .o_overflow  (o_overflow),
`endif
      .o_reg_write (o_reg_write)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw, input logic v);
      i_ALUctl    = code;
      i_data_a    = a;
      i_data_b    = b;
      i_rd_addr   = rd;
      i_reg_write = rw;
      i_valid     = v;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_ovf(input string tag, input logic exp);
`ifdef ALU_OVERFLOW_EN
      chk(tag, {31'd0, o_overflow}, {31'd0, exp});
`endif
   endtask

   initial begin
      i_reset = 1'b1;
      i_stall = 1'b0;
      i_flush = 1'b0;
      drive(4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      #12;
      chk("rst_valid",  {31'd0, o_valid},     32'd0);
      chk("rst_result", o_result,             32'd0);
      chk("rst_zero",   {31'd0, o_zero},      32'd0);
      chk("rst_rd",     {27'd0, o_rd_addr},   32'd0);
      chk("rst_rw",     {31'd0, o_reg_write}, 32'd0);
      chk_ovf("rst_ovf", 1'b0);
      @(negedge i_clk);
      i_reset = 1'b0;

      drive(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3, 1'b1, 1'b1);
      tick();
      chk("add_result", o_result,             32'h8000_0000);
      chk("add_zero",   {31'd0, o_zero},      32'd0);
      chk("add_rd",     {27'd0, o_rd_addr},   32'd3);
      chk("add_rw",     {31'd0, o_reg_write}, 32'd1);
      chk("add_valid",  {31'd0, o_valid},     32'd1);
      chk_ovf("add_ovf", 1'b1);

      drive(4'b0110, 32'h0000_1234, 32'h0000_1234, 5'd4, 1'b1, 1'b1);
      tick();
      chk("sub_eq_result", o_result,        32'd0);
      chk("sub_eq_zero",   {31'd0, o_zero}, 32'd1);
      chk_ovf("sub_eq_ovf", 1'b0);

      drive(4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd4, 1'b1, 1'b1);
      tick();
      chk("sub_ovf_result", o_result, 32'h7FFF_FFFF);
      chk_ovf("sub_ovf", 1'b1);

      drive(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 1'b1, 1'b1);
      tick();
      chk("slt_neg_lt", o_result, 32'd1);

      drive(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b1);
      tick();
      chk("slt_pos_ge",  o_result,        32'd0);
      chk("slt_ge_zero", {31'd0, o_zero}, 32'd1);

      drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 1'b1, 1'b1);
      tick();
      chk("and", o_result, 32'hF000_F000);
      drive(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 1'b1, 1'b1);
      tick();
      chk("or", o_result, 32'hFFF0_FFF0);
      drive(4'b1101, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 1'b1, 1'b1);
      tick();
      chk("xor", o_result, 32'h0FF0_0FF0);
      drive(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 1'b1, 1'b1);
      tick();
      chk("nor", o_result, 32'h000F_000F);
      drive(4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 1'b1, 1'b1);
      tick();
      chk("bad_code_result", o_result,        32'd0);
      chk("bad_code_zero",   {31'd0, o_zero}, 32'd1);
      chk_ovf("bad_code_ovf", 1'b0);

      drive(4'b0010, 32'd2, 32'd3, 5'd9, 1'b1, 1'b0);
      tick();
      chk("bubble_result", o_result,             32'd5);
      chk("bubble_valid",  {31'd0, o_valid},     32'd0);
      chk("bubble_rw",     {31'd0, o_reg_write}, 32'd0);
      chk("bubble_rd",     {27'd0, o_rd_addr},   32'd9);

      drive(4'b0010, 32'd5, 32'd6, 5'd10, 1'b1, 1'b1);
      tick();
      chk("pre_stall_result", o_result, 32'd11);
      i_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(4'b1101, 32'hA5A5_0000 + i, 32'h0000_5A5A, 5'd20 + 5'(i), 1'b0, 1'b0);
         tick();
         chk("stall_result", o_result,             32'd11);
         chk("stall_rd",     {27'd0, o_rd_addr},   32'd10);
         chk("stall_valid",  {31'd0, o_valid},     32'd1);
         chk("stall_rw",     {31'd0, o_reg_write}, 32'd1);
      end
      i_stall = 1'b0;
      drive(4'b0110, 32'd100, 32'd58, 5'd12, 1'b1, 1'b1);
      tick();
      chk("unstall_result", o_result,           32'd42);
      chk("unstall_rd",     {27'd0, o_rd_addr}, 32'd12);

      i_stall = 1'b1;
      i_flush = 1'b1;
      drive(4'b0010, 32'd7, 32'd8, 5'd13, 1'b1, 1'b1);
      tick();
      chk("flush_valid",  {31'd0, o_valid},     32'd0);
      chk("flush_rw",     {31'd0, o_reg_write}, 32'd0);
      chk("flush_result", o_result,             32'd0);
      chk("flush_zero",   {31'd0, o_zero},      32'd0);
      chk("flush_rd",     {27'd0, o_rd_addr},   32'd0);
      chk_ovf("flush_ovf", 1'b0);
      i_stall = 1'b0;
      i_flush = 1'b0;

      drive(4'b0010, 32'd5, 32'd6, 5'd14, 1'b1, 1'b1);
      tick();
      chk("pre_rst_result", o_result, 32'd11);
      i_stall = 1'b1;
      tick();
      #2;
      i_reset = 1'b1;
      #1;
      chk("async_rst_result", o_result,             32'd0);
      chk("async_rst_valid",  {31'd0, o_valid},     32'd0);
      chk("async_rst_rd",     {27'd0, o_rd_addr},   32'd0);
      chk("async_rst_rw",     {31'd0, o_reg_write}, 32'd0);
      #1;
      i_reset = 1'b0;
      i_stall = 1'b0;
      drive(4'b0010, 32'd1, 32'd2, 5'd15, 1'b1, 1'b1);
      tick();
      chk("post_rst_result", o_result,             32'd3);
      chk("post_rst_valid",  {31'd0, o_valid},     32'd1);
      chk("post_rst_rw",     {31'd0, o_reg_write}, 32'd1);
      chk("post_rst_rd",     {27'd0, o_rd_addr},   32'd15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
